// File: rtl/collatz_sched_pkg.sv
// collatz_sched_pkg: shared state encoding, default widths and id-width helper for the collatz scheduler.
package collatz_sched_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_t;
    localparam int DEF_W = 27;
    localparam int DEF_CNT_W = 16;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/collatz_sched_rr_pick.sv
// rr_pick: combinational round-robin picker, first asserted request at or after ptr.
module rr_pick
    import collatz_sched_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]        grant,
    output logic [clog2(N_REQ)-1:0] idx,
    output logic                    any
);
    localparam int ID_W = clog2(N_REQ);
    logic [ID_W-1:0] j;
    // Scan from the farthest slot back to ptr so the nearest hit is written last.
    always_comb begin
        idx = '0;
        j = '0;
        any = |req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = ID_W'((int'(ptr) + k) % N_REQ);
            if (req[j]) idx = j;
        end
        grant = any ? (N_REQ'(1) << idx) : '0;
    end
endmodule

// File: rtl/collatz_sched.sv
// collatz_sched: round-robin scheduler sharing one collatz datapath, one op in flight,
// with optional wait timeout and draining of late results.
module collatz_sched
    import collatz_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W = DEF_W,
    parameter int CNT_W = DEF_CNT_W,
    parameter int TIMEOUT = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*W-1:0]      req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [clog2(N_REQ)-1:0] resp_id,
    output logic [W-1:0]            resp_data,
    output logic [CNT_W-1:0]        resp_cycles,
    output logic                    resp_timeout,
    output logic                    dp_start,
    output logic [W-1:0]            dp_a,
    input  logic                    dp_done,
    input  logic [W-1:0]            dp_b,
    output logic                    busy,
    output logic                    err_spurious
);
    localparam int ID_W = clog2(N_REQ);
    state_t state, state_nx;
    logic [ID_W-1:0] rr_ptr, gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic [W-1:0] op_sel;
    logic [CNT_W-1:0] cnt;
    logic gnt_any, drain_owed, stale, done_ok, tmo_hit;

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req(req_valid), .ptr(rr_ptr), .grant(gnt), .idx(gnt_idx), .any(gnt_any)
    );

    assign done_ok = state == WAIT && dp_done;
    assign tmo_hit = state == WAIT && !dp_done && TIMEOUT != 0 && cnt == CNT_W'(TIMEOUT - 1);

    always_comb begin
        op_sel = '0;
        for (int i = 0; i < N_REQ; i++) if (gnt[i]) op_sel = req_data[i*W +: W];
    end

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = gnt_any ? ISSUE : IDLE;
            ISSUE:   state_nx = WAIT;
            WAIT:    state_nx = (dp_done || tmo_hit) ? RESP : WAIT;
            RESP:    state_nx = !resp_ready ? RESP : (drain_owed && !dp_done) ? DRAIN : IDLE;
            DRAIN:   state_nx = dp_done ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        req_ready = state == IDLE ? gnt : '0;
        dp_start = state == ISSUE;
        resp_valid = state == RESP;
        busy = state != IDLE;
    end

    // stale remembers an op abandoned by reset so its late result is not flagged.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            resp_id <= '0;
            resp_data <= '0;
            resp_cycles <= '0;
            resp_timeout <= 1'b0;
            dp_a <= '0;
            cnt <= '0;
            drain_owed <= 1'b0;
            err_spurious <= 1'b0;
            stale <= state inside {ISSUE, WAIT, DRAIN} || drain_owed;
        end else begin
            if (state == IDLE && gnt_any) begin
                dp_a <= op_sel;
                resp_id <= gnt_idx;
            end
            cnt <= state == ISSUE ? '0 : (state == WAIT && cnt != '1) ? cnt + 1'b1 : cnt;
            if (done_ok || tmo_hit) begin
                resp_data <= done_ok ? dp_b : '0;
                resp_timeout <= tmo_hit;
                resp_cycles <= cnt == '1 ? cnt : cnt + 1'b1;
                drain_owed <= tmo_hit;
            end else if (dp_done) drain_owed <= 1'b0;
            if (dp_done) stale <= 1'b0;
            if (dp_done && !stale && (state == IDLE || state == ISSUE || (state == RESP && !drain_owed)))
                err_spurious <= 1'b1;
            if (resp_valid && resp_ready) rr_ptr <= ID_W'((int'(resp_id) + 1) % N_REQ);
        end
    end
endmodule
